// File: rtl/gain_driver.sv
// Sequences one sample through an external gain block: optional coefficient
// reload with readback check, start pulse, bounded wait for the result, output hold.
module gain_driver #(
    parameter int A_WDT    = 16,
    parameter int COEF_WDT = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic signed [A_WDT-1:0] inA,
    input  logic [31:0]             inCoef,
    output logic                    outValid,
    input  logic                    outReady,
    output logic signed [A_WDT-1:0] outY,
    output logic                    avsWr,
    output logic [31:0]             avsWrData,
    input  logic [31:0]             avsRdData,
    output logic                    st,
    output logic signed [A_WDT-1:0] a,
    input  logic                    rdy,
    input  logic signed [A_WDT-1:0] y,
    output logic                    errTo,
    output logic                    errCfg,
    input  logic                    errClr
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        START,
        WAIT,
        HOLD
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [A_WDT-1:0] out_y_q, out_y_d;
    logic                    avs_wr_q, avs_wr_d;
    logic [31:0]             avs_wr_data_q, avs_wr_data_d;
    logic                    st_q, st_d;
    logic signed [A_WDT-1:0] a_q, a_d;
    logic                    err_to_q, err_to_d;
    logic                    err_cfg_q, err_cfg_d;
    logic                    coef_loaded_q, coef_loaded_d;
    logic [31:0]             last_coef_q, last_coef_d;
    logic [15:0]             cnt_q, cnt_d;
    logic signed [A_WDT-1:0] smp_q, smp_d;
    logic [31:0]             coef_q, coef_d;
    logic                    set_to, set_cfg;
    logic                    unused_rd;

    assign unused_rd = ^(avsRdData >> COEF_WDT);

    always_comb begin
        state_d       = state_q;
        out_y_d       = out_y_q;
        coef_loaded_d = coef_loaded_q;
        last_coef_d   = last_coef_q;
        cnt_d         = cnt_q;
        smp_d         = smp_q;
        coef_d        = coef_q;
        set_to        = 1'b0;
        set_cfg       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_ready_q && inValid) begin
                    smp_d   = inA;
                    coef_d  = inCoef;
                    state_d = (!coef_loaded_q || inCoef != last_coef_q)
                              ? LOAD : START;
                end
            end
            LOAD: begin
                last_coef_d   = coef_q;
                coef_loaded_d = 1'b1;
                state_d       = CHECK;
            end
            CHECK: begin
                if (avsRdData[COEF_WDT-1:0] != last_coef_q[COEF_WDT-1:0])
                    set_cfg = 1'b1;
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // rdy is only looked at from here on, so a rdy coincident with st is ignored
                if (rdy) begin
                    out_y_d = y;
                    state_d = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    set_to  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (outReady)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered decodes of the next state
        in_ready_d    = (state_d == IDLE);
        out_valid_d   = (state_d == HOLD);
        avs_wr_d      = (state_d == LOAD);
        avs_wr_data_d = (state_d == LOAD) ? coef_d : avs_wr_data_q;
        st_d          = (state_d == START);
        a_d           = st_d ? smp_d : '0;
        err_to_d      = set_to | (err_to_q & ~errClr);
        err_cfg_d     = set_cfg | (err_cfg_q & ~errClr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_y_q       <= '0;
            avs_wr_q      <= 1'b0;
            avs_wr_data_q <= '0;
            st_q          <= 1'b0;
            a_q           <= '0;
            err_to_q      <= 1'b0;
            err_cfg_q     <= 1'b0;
            coef_loaded_q <= 1'b0;
            last_coef_q   <= '0;
            cnt_q         <= '0;
            smp_q         <= '0;
            coef_q        <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_y_q       <= out_y_d;
            avs_wr_q      <= avs_wr_d;
            avs_wr_data_q <= avs_wr_data_d;
            st_q          <= st_d;
            a_q           <= a_d;
            err_to_q      <= err_to_d;
            err_cfg_q     <= err_cfg_d;
            coef_loaded_q <= coef_loaded_d;
            last_coef_q   <= last_coef_d;
            cnt_q         <= cnt_d;
            smp_q         <= smp_d;
            coef_q        <= coef_d;
        end
    end

    assign inReady   = in_ready_q;
    assign outValid  = out_valid_q;
    assign outY      = out_y_q;
    assign avsWr     = avs_wr_q;
    assign avsWrData = avs_wr_data_q;
    assign st        = st_q;
    assign a         = a_q;
    assign errTo     = err_to_q;
    assign errCfg    = err_cfg_q;

endmodule

// File: tb/tb_gain_driver.sv
// Directed bench for gain_driver with a behavioural gain block
// computing y = a*coef >>> 14.
module tb_gain_driver;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               inValid = 1'b0;
    logic               inReady;
    logic signed [15:0] inA = '0;
    logic [31:0]        inCoef = '0;
    logic               outValid;
    logic               outReady = 1'b1;
    logic signed [15:0] outY;
    logic               avsWr;
    logic [31:0]        avsWrData;
    logic [31:0]        avsRdData;
    logic               st;
    logic signed [15:0] a;
    logic               rdy;
    logic signed [15:0] y;
    logic               errTo;
    logic               errCfg;
    logic               errClr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic               rdy_en = 1'b1;
    logic               bad_rd = 1'b0;
    logic [31:0]        g_coef;
    logic signed [15:0] g_a;
    logic               g_busy;
    logic signed [31:0] g_prod;

    gain_driver #(.A_WDT(16), .COEF_WDT(16), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inReady(inReady), .inA(inA), .inCoef(inCoef),
        .outValid(outValid), .outReady(outReady), .outY(outY),
        .avsWr(avsWr), .avsWrData(avsWrData), .avsRdData(avsRdData),
        .st(st), .a(a), .rdy(rdy), .y(y),
        .errTo(errTo), .errCfg(errCfg), .errClr(errClr)
    );

    always #5 clk = ~clk;

    // Gain block model: one-cycle turnaround after st
    assign g_prod    = g_a * $signed(g_coef[15:0]);
    assign avsRdData = bad_rd ? 32'd0 : g_coef;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            g_coef <= '0;
            g_a    <= '0;
            g_busy <= 1'b0;
            rdy    <= 1'b0;
            y      <= '0;
        end else begin
            rdy <= 1'b0;
            if (avsWr) g_coef <= avsWrData;
            if (st) begin
                g_a    <= a;
                g_busy <= 1'b1;
            end else if (g_busy && rdy_en) begin
                rdy    <= 1'b1;
                y      <= g_prod[29:14];
                g_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!inReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready"}, inReady, 1);
    endtask

    task automatic run_txn(input string nm, input logic signed [15:0] ia,
                           input logic [31:0] ic, input bit ld,
                           input logic signed [15:0] ey);
        int k_wr = -1, k_st = -1, k_out = -1, n_wr = 0;
        logic [31:0] wdata = '0;
        logic signed [15:0] av = '0, yv = '0;
        bit both = 0, leak = 0, rdy_hi = 0;
        wait_ready(nm);
        inValid = 1'b1;
        inA     = ia;
        inCoef  = ic;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            inValid = 1'b0;
            if (inReady) rdy_hi = 1;
            if (avsWr && st) both = 1;
            if (!st && a != 0) leak = 1;
            if (avsWr) begin
                n_wr++;
                k_wr  = k;
                wdata = avsWrData;
            end
            if (st) begin
                k_st = k;
                av   = a;
            end
            if (outValid) begin
                k_out = k;
                yv    = outY;
                break;
            end
        end
        check({nm, "_nwr"}, n_wr, ld ? 1 : 0);
        check({nm, "_kwr"}, k_wr, ld ? 1 : -1);
        check({nm, "_wdata"}, wdata, ld ? ic : 32'd0);
        check({nm, "_kst"}, k_st, ld ? 3 : 1);
        check({nm, "_a"}, av, ia);
        check({nm, "_kout"}, k_out, ld ? 6 : 4);
        check({nm, "_outY"}, yv, ey);
        check({nm, "_flags"}, {both, leak, rdy_hi}, 0);
    endtask

    typedef struct {
        logic signed [15:0] a;
        logic [31:0]        coef;
        bit                 ld;
        logic signed [15:0] y;
    } vec_t;

    vec_t vt[6];

    task automatic check_reset_outs(input string nm);
        check({nm, "_bits"}, {inReady, outValid, avsWr, st, errTo, errCfg}, 0);
        check({nm, "_outY"}, outY, 0);
        check({nm, "_a"}, a, 0);
        check({nm, "_wdata"}, avsWrData, 0);
    endtask

    initial begin
        logic signed [15:0] y0;
        int ov, kk;
        bit e65, e66, r66, unstable;

        vt[0] = '{16'sd100,  32'h4000, 1'b1, 16'sd100};
        vt[1] = '{-16'sd50,  32'h4000, 1'b0, -16'sd50};
        vt[2] = '{16'sd200,  32'h2000, 1'b1, 16'sd100};
        vt[3] = '{-16'sd300, 32'h2000, 1'b0, -16'sd150};
        vt[4] = '{16'sd100,  32'h8000, 1'b1, -16'sd200};
        vt[5] = '{16'sd7,    32'h4000, 1'b1, 16'sd7};

        // Reset state and first-clock inReady
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        reset = 1'b1;
        #1 check("ready_before_clk", inReady, 0);
        @(negedge clk);
        check("ready_first_clk", inReady, 1);

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vt[i].a, vt[i].coef, vt[i].ld, vt[i].y);
        check("no_err_after_vecs", {errTo, errCfg}, 0);

        // Readback mismatch: flag set, transaction still completes
        bad_rd = 1'b1;
        run_txn("cfgerr", 16'sd16, 32'h1234, 1'b1, 16'sd4);
        bad_rd = 1'b0;
        check("errCfg_set", errCfg, 1);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        check("errCfg_clr", errCfg, 0);

        // Timeout, with errClr held across the setting edge
        rdy_en = 1'b0;
        wait_ready("to");
        inValid = 1'b1;
        inA     = 16'sd5;
        inCoef  = 32'h1234;
        ov = 0;
        e65 = 0; e66 = 0; r66 = 0;
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            inValid = 1'b0;
            if (outValid) ov++;
            if (k == 60) errClr = 1'b1;
            if (k == 65) e65 = errTo;
            if (k == 66) begin
                e66    = errTo;
                r66    = inReady;
                errClr = 1'b0;
            end
        end
        check("to_not_early", e65, 0);
        check("to_set_wins", e66, 1);
        check("to_ready", r66, 1);
        check("to_no_outvalid", ov, 0);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        check("to_clr", errTo, 0);
        rdy_en = 1'b1;

        // Downstream stall in HOLD
        outReady = 1'b0;
        wait_ready("hold");
        inValid = 1'b1;
        inA     = 16'sd9;
        inCoef  = 32'h1234;
        kk = 0;
        do begin
            @(negedge clk);
            inValid = 1'b0;
            kk++;
        end while (!outValid && kk < 20);
        check("hold_lat", kk, 4);
        y0 = outY;
        check("hold_y", y0, 2);
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!outValid || outY != y0 || inReady) unstable = 1;
        end
        check("hold_stable", unstable, 0);
        outReady = 1'b1;
        @(negedge clk);
        check("hold_release", {outValid, inReady}, 2'b01);
        check("hold_y_kept", outY, 2);

        // Reset while in WAIT, then a reload is required
        rdy_en = 1'b0;
        wait_ready("rstw");
        inValid = 1'b1;
        inA     = 16'sd3;
        inCoef  = 32'h1234;
        @(negedge clk);
        inValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outs("rstw");
        @(negedge clk);
        reset  = 1'b1;
        rdy_en = 1'b1;
        run_txn("reload", 16'sd1000, 32'h1234, 1'b1, 16'sd284);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gain_driver.md
GAIN_DRIVER -- requirements
Module: gain_driver

Interface
REQ-001 SHALL have parameter A_WDT, default 16: sample width, signed.
REQ-002 SHALL have parameter COEF_WDT, default 16: coefficient width; coefficient occupies inCoef[COEF_WDT-1:0].
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for rdy, range 2..65535.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port inValid, input, 1: upstream sample/coef pair valid.
REQ-007 SHALL have port inReady, output, 1: driver accepts the pair.
REQ-008 SHALL have port inA, input, A_WDT: signed sample.
REQ-009 SHALL have port inCoef, input, 32: coefficient word for this sample.
REQ-010 SHALL have port outValid, output, 1: result valid.
REQ-011 SHALL have port outReady, input, 1: downstream accepts result.
REQ-012 SHALL have port outY, output, A_WDT: signed result.
REQ-013 SHALL have port avsWr, output, 1: coefficient write strobe to gain.
REQ-014 SHALL have port avsWrData, output, 32: coefficient write data.
REQ-015 SHALL have port avsRdData, input, 32: coefficient readback from gain.
REQ-016 SHALL have port st, output, 1: gain start pulse.
REQ-017 SHALL have port a, output, A_WDT: gain operand.
REQ-018 SHALL have port rdy, input, 1: gain result ready.
REQ-019 SHALL have port y, input, A_WDT: gain result.
REQ-020 SHALL have port errTo, output, 1: sticky timeout flag.
REQ-021 SHALL have port errCfg, output, 1: sticky readback-mismatch flag.
REQ-022 SHALL have port errClr, input, 1: synchronous clear of errTo and errCfg.

Function
REQ-023 SHALL implement FSM states IDLE, LOAD, CHECK, START, WAIT, HOLD.
REQ-024 IDLE: inReady=1; on inValid=1, latch inA and inCoef and go to LOAD if coefLoaded=0 or the latched coef differs from lastCoef; otherwise go to START.
REQ-025 LOAD: avsWr=1 and avsWrData=latched coef for exactly one cycle; update lastCoef; set coefLoaded=1; go to CHECK.
REQ-026 CHECK: compare avsRdData[COEF_WDT-1:0] with lastCoef[COEF_WDT-1:0]; on mismatch set errCfg; always go to START.
REQ-027 START: st=1 and a=latched sample for exactly one cycle; clear the timeout counter; go to WAIT.
REQ-028 WAIT: on rdy=1, capture y into outY and go to HOLD; rdy arriving in the same cycle as st SHALL be ignored.
REQ-029 WAIT timeout: after TIMEOUT cycles in WAIT without rdy, set errTo, drop the sample with no outValid, and return to IDLE.
REQ-030 HOLD: outValid=1 with outY stable until outReady=1; on that cycle go to IDLE.
REQ-031 inReady SHALL be 1 only in IDLE; no second pair accepted until HOLD completes or a timeout occurs.
REQ-032 avsWr and st SHALL never be asserted in the same cycle; a is driven only while st=1 and is 0 otherwise.
REQ-033 Minimum latency, coefficient unchanged: accept at cycle N, st at N+1, outValid the cycle after rdy is seen.
REQ-034 Minimum latency, coefficient changed: avsWr at N+1, CHECK at N+2, st at N+3.
REQ-035 errClr=1 SHALL clear both flags; if a set event occurs in the same cycle, the set SHALL win.
REQ-036 outY SHALL hold the last captured value outside HOLD; no arithmetic is performed on y.

Reset
REQ-037 While reset=0: state=IDLE, inReady=0, outValid=0, outY=0, avsWr=0, avsWrData=0, st=0, a=0, errTo=0, errCfg=0, coefLoaded=0, lastCoef=0, timeout counter=0.
REQ-038 inReady SHALL rise in the first clock after reset deasserts.
REQ-039 Reset mid-operation (any state) SHALL abort the transaction, produce no further strobes, and require a coefficient reload on the next sample.

Verification
REQ-040 After reset, send inA=100, inCoef=0x4000 with a gain model giving y=a*coef>>>14 -> one avsWr with 0x4000, then st with a=100, then outValid with outY=100.
REQ-041 Send a second sample with inA=-50 and the same coefficient -> no avsWr, st at N+1, outY=-50.
REQ-042 Send inCoef=0x2000 with inA=200 -> avsWr with 0x2000 at N+1, st at N+3, outY=100.
REQ-043 Gain model never asserts rdy, TIMEOUT=64 -> errTo=1 after 64 WAIT cycles, no outValid, inReady=1; then errClr=1 -> errTo=0.
REQ-044 avsRdData forced to 0 during CHECK -> errCfg=1 and the transaction still completes.
REQ-045 outReady held at 0 for 10 cycles in HOLD -> outValid and outY stable and inReady=0; assert reset in WAIT -> all outputs at their reset values.
